// File: rtl/wall_follower_ctrl_pkg.sv
// Shared definitions for the wall-following controller: state encodings
// (also used by the debug/telemetry blocks) and state-class helpers.
package wall_follower_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE         = 3'd0,
        ST_PROCURANDO   = 3'd1,
        ST_ACOMPANHANDO = 3'd2,
        ST_ROTACIONANDO = 3'd3,
        ST_BUSCA_GIRO   = 3'd4
    } state_t;

    // States in which the robot drives forward
    function automatic logic is_forward(input state_t s);
        return (s == ST_PROCURANDO) || (s == ST_ACOMPANHANDO);
    endfunction

    // States in which the robot rotates in place
    function automatic logic is_turning(input state_t s);
        return (s == ST_ROTACIONANDO) || (s == ST_BUSCA_GIRO);
    endfunction

endpackage

// File: rtl/wall_follower_ctrl_if.sv
// Bundle of controller inputs (run control + raw sensors) and motor/debug
// outputs. master = host/sensor side, slave = the controller.
interface wall_follower_ctrl_if;
    import wall_follower_ctrl_pkg::*;

    logic               enable;
    logic               side_sel;
    logic               head;
    logic               left;
    logic               right;
    logic               avancar;
    logic               girar;
    logic               dir_giro;
    logic [STATE_W-1:0] state_o;
    logic               timeout_flag;

    modport master (
        output enable, side_sel, head, left, right,
        input  avancar, girar, dir_giro, state_o, timeout_flag
    );

    modport slave (
        input  enable, side_sel, head, left, right,
        output avancar, girar, dir_giro, state_o, timeout_flag
    );

endinterface

// File: rtl/wall_follower_ctrl_debounce.sv
// Two-flop synchronizer followed by a debounce counter for one raw sensor.
// The debounced value flips only after DEBOUNCE_CYCLES consecutive synced
// samples that disagree with it; any agreeing sample clears the count.
module sensor_debounce
    import wall_follower_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic db
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic [CNT_W-1:0] cnt;

    // Synchronize the raw input and qualify changes by a stable run length
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            cnt    <= '0;
            db     <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            if (sync_b != db) begin
                if (cnt >= LAST) begin
                    db  <= sync_b;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/wall_follower_ctrl.sv
// Wall-following robot controller: debounced sensors, selectable followed
// wall, minimum rotation time and a timed spin-search. Move commands are
// registered and decoded from next_state so they switch with the state.
module wall_follower_ctrl
    import wall_follower_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TURN_MIN_CYCLES = 8,
    parameter int SEARCH_TIMEOUT  = 255,
    parameter int CNT_W           = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    wall_follower_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] SEARCH_LAST = CNT_W'(SEARCH_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TURN_LAST   = CNT_W'(TURN_MIN_CYCLES - 1);

    state_t           state;
    state_t           next_state;
    logic             head_db;
    logic             left_db;
    logic             right_db;
    logic             side_q;
    logic             wall;
    logic [CNT_W-1:0] search_cnt;
    logic [CNT_W-1:0] turn_cnt;
    logic             avancar_q;
    logic             girar_q;
    logic             dir_giro_q;
    logic             timeout_q;

    // Counters hold at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_head (
        .clock(clock), .reset(reset), .raw(bus.head), .db(head_db)
    );
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_left (
        .clock(clock), .reset(reset), .raw(bus.left), .db(left_db)
    );
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_right (
        .clock(clock), .reset(reset), .raw(bus.right), .db(right_db)
    );

    assign wall = side_q ? right_db : left_db;

    // Next-state decision; enable low overrides everything
    always_comb begin
        next_state = ST_IDLE;
        if (bus.enable) begin
            case (state)
                ST_IDLE: next_state = ST_PROCURANDO;
                ST_PROCURANDO: begin
                    if (head_db)                         next_state = ST_ROTACIONANDO;
                    else if (wall)                       next_state = ST_ACOMPANHANDO;
                    else if (search_cnt == SEARCH_LAST)  next_state = ST_BUSCA_GIRO;
                    else                                 next_state = ST_PROCURANDO;
                end
                ST_ACOMPANHANDO: begin
                    if (head_db && wall)                 next_state = ST_ROTACIONANDO;
                    else if (!wall)                      next_state = ST_PROCURANDO;
                    else                                 next_state = ST_ACOMPANHANDO;
                end
                ST_ROTACIONANDO: begin
                    if (!head_db && wall && (turn_cnt >= TURN_LAST))
                                                         next_state = ST_ACOMPANHANDO;
                    else                                 next_state = ST_ROTACIONANDO;
                end
                ST_BUSCA_GIRO: begin
                    if (head_db)                         next_state = ST_ROTACIONANDO;
                    else if (wall)                       next_state = ST_ACOMPANHANDO;
                    else if (search_cnt == SEARCH_LAST)  next_state = ST_PROCURANDO;
                    else                                 next_state = ST_BUSCA_GIRO;
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // Dwell counters: cleared on any state change, search_cnt shared by
    // PROCURANDO and BUSCA_GIRO since only one is active at a time
    always_ff @(posedge clock) begin
        if (!reset) begin
            search_cnt <= '0;
            turn_cnt   <= '0;
        end else if (next_state != state) begin
            search_cnt <= '0;
            turn_cnt   <= '0;
        end else begin
            if ((state == ST_PROCURANDO) || (state == ST_BUSCA_GIRO))
                search_cnt <= sat_inc(search_cnt);
            if (state == ST_ROTACIONANDO)
                turn_cnt <= sat_inc(turn_cnt);
        end
    end

    // State register, followed-wall latch and registered move commands
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= ST_IDLE;
            side_q     <= 1'b0;
            avancar_q  <= 1'b0;
            girar_q    <= 1'b0;
            dir_giro_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state     <= next_state;
            avancar_q <= is_forward(next_state);
            girar_q   <= is_turning(next_state);
            timeout_q <= (state == ST_PROCURANDO) && (next_state == ST_BUSCA_GIRO);
            if ((state == ST_IDLE) && (next_state == ST_PROCURANDO))
                side_q <= bus.side_sel;
            // Rotate away from the followed wall; value is kept between turns
            if (is_turning(next_state))
                dir_giro_q <= ~side_q;
        end
    end

    assign bus.avancar      = avancar_q;
    assign bus.girar        = girar_q;
    assign bus.dir_giro     = dir_giro_q;
    assign bus.timeout_flag = timeout_q;
    assign bus.state_o      = state;

endmodule
